// File: rtl/alu_seq_ctrl.sv
// Hardwired control sequencer for the three-register ALU instruction class.
// Define ALU_SEQ_MULDIV_EN to add mul/div with a T6 HI/LO writeback phase.
module alu_seq_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        incPC,
    output logic        MARin,
    output logic        Zin,
    output logic        ZLowOut,
    output logic        ZHighOut,
    output logic        PCin,
    output logic        read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [4:0]  opcode,
    output logic        done,
    output logic        illegal,
    output logic        halted,
    output logic        mem_fault
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, HALT
`ifdef ALU_SEQ_MULDIV_EN
        , T6
`endif
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   wait_cnt;
    logic            at_limit;
    logic            fault_set;
    logic [4:0]      op;
    logic            legal;
    logic            ir_unused;
`ifdef ALU_SEQ_MULDIV_EN
    logic            md_op;
`endif

    assign op        = ir[31:27];
    assign ir_unused = ^ir[14:0];
    assign at_limit  = (wait_cnt == CW'(MEM_TIMEOUT - 1));
    assign halted    = (state == HALT);

`ifdef ALU_SEQ_MULDIV_EN
    assign md_op = (op == 5'b01111) || (op == 5'b10000);
    assign legal = ((op >= 5'b00011) && (op <= 5'b01010)) || md_op;
`else
    assign legal = (op >= 5'b00011) && (op <= 5'b01010);
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_fault <= 1'b0;
        end else begin
            state <= state_nxt;
            // T0 is the only way into T1, so clearing here restarts the wait window
            if (state == T0)
                wait_cnt <= '0;
            else if (state == T1 && !mem_ready && !at_limit)
                wait_cnt <= wait_cnt + 1'b1;
            if (fault_set)
                mem_fault <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        fault_set = 1'b0;
        PCout = 1'b0; incPC = 1'b0; MARin = 1'b0; Zin = 1'b0;
        ZLowOut = 1'b0; ZHighOut = 1'b0; PCin = 1'b0; read = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
        HIin = 1'b0; LOin = 1'b0;
        Rin = '0; Rout = '0; opcode = '0;
        done = 1'b0; illegal = 1'b0;
        case (state)
            IDLE: state_nxt = run ? T0 : IDLE;
            T0: begin
                PCout = 1'b1; MARin = 1'b1; incPC = 1'b1; Zin = 1'b1;
                state_nxt = T1;
            end
            T1: begin
                ZLowOut = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1;
                // ready on the last allowed cycle still wins over the fault
                if (mem_ready) begin
                    state_nxt = T2;
                end else if (at_limit) begin
                    state_nxt = HALT;
                    fault_set = 1'b1;
                end
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                state_nxt = T3;
            end
            T3: begin
                if (legal) begin
                    Rout = 16'h0001 << ir[22:19];
                    Yin  = 1'b1;
                    state_nxt = T4;
                end else if (op == 5'b11011) begin
                    state_nxt = HALT;
                end else begin
                    illegal   = 1'b1;
                    state_nxt = run ? T0 : IDLE;
                end
            end
            T4: begin
                Rout   = 16'h0001 << ir[18:15];
                Zin    = 1'b1;
                opcode = op;
                state_nxt = T5;
            end
            T5: begin
                ZLowOut = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
                if (md_op) begin
                    LOin      = 1'b1;
                    state_nxt = T6;
                end else begin
                    Rin       = 16'h0001 << ir[26:23];
                    done      = 1'b1;
                    state_nxt = run ? T0 : IDLE;
                end
`else
                Rin       = 16'h0001 << ir[26:23];
                done      = 1'b1;
                state_nxt = run ? T0 : IDLE;
`endif
            end
`ifdef ALU_SEQ_MULDIV_EN
            T6: begin
                ZHighOut  = 1'b1;
                HIin      = 1'b1;
                done      = 1'b1;
                state_nxt = run ? T0 : IDLE;
            end
`endif
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed cases then random instructions, each checked
// cycle by cycle against a per-instruction expected strobe trace.
module tb_alu_seq_ctrl;

    localparam int MEM_TO = 15;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        run = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] ir = '0;
    logic PCout, incPC, MARin, Zin, ZLowOut, ZHighOut, PCin, read;
    logic MDRin, MDRout, IRin, Yin, HIin, LOin;
    logic [15:0] Rin, Rout;
    logic [4:0]  opcode;
    logic done, illegal, halted, mem_fault;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic pc_out, inc_pc, mar_in, z_in, zlo_out, zhi_out, pc_in, rd;
        logic mdr_in, mdr_out, ir_in, y_in, hi_in, lo_in;
        logic [15:0] rin, rout;
        logic [4:0]  opc;
        logic done, illegal, halted, mem_fault;
    } out_t;

    out_t obs;
    assign obs = {PCout, incPC, MARin, Zin, ZLowOut, ZHighOut, PCin, read,
                  MDRin, MDRout, IRin, Yin, HIin, LOin, Rin, Rout, opcode,
                  done, illegal, halted, mem_fault};

    alu_seq_ctrl #(.MEM_TIMEOUT(MEM_TO)) dut (
        .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
        .PCout(PCout), .incPC(incPC), .MARin(MARin), .Zin(Zin),
        .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .PCin(PCin), .read(read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout), .opcode(opcode),
        .done(done), .illegal(illegal), .halted(halted), .mem_fault(mem_fault)
    );

    always #5 clock = ~clock;

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic check(input out_t e, input string tag);
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    // Called at posedge+1: drive inputs, check at negedge, return at next posedge+1.
    task automatic cyc(input logic r, input logic mr, input out_t e, input string tag);
        run = r;
        mem_ready = mr;
        @(negedge clock);
        check(e, tag);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear = 1'b0;
        #1;
        check('0, "reset_async");
        @(posedge clock);
        #1;
        clear = 1'b1;
        run = 1'b0;
    endtask

    // Entered with the DUT in T0. st: 0 = IDLE next, 1 = T0 next, 2 = HALT.
    task automatic exec(input logic [31:0] instr, input int waits, input logic run_after,
                        input bit abort_t4, output int st);
        out_t e;
        logic [4:0] op;
        bit alu, md, hlt;
        op  = instr[31:27];
        alu = op inside {[5'd3:5'd10]};
        md  = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
        md  = op inside {5'd15, 5'd16};
`endif
        hlt = (op == 5'd27);
        ir  = instr;

        e = '0; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1;
        cyc(rbit(), rbit(), e, "T0");

        e = '0; e.zlo_out = 1; e.pc_in = 1; e.rd = 1; e.mdr_in = 1;
        if (waits >= MEM_TO) begin
            for (int i = 0; i < MEM_TO; i++) cyc(rbit(), 1'b0, e, "T1_timeout");
            e = '0; e.halted = 1; e.mem_fault = 1;
            for (int i = 0; i < 3; i++) cyc(rbit(), rbit(), e, "HALT_fault");
            st = 2;
            return;
        end
        for (int i = 0; i <= waits; i++) cyc(rbit(), (i == waits), e, "T1");

        e = '0; e.mdr_out = 1; e.ir_in = 1;
        cyc(rbit(), rbit(), e, "T2");

        if (hlt) begin
            cyc(rbit(), rbit(), '0, "T3_halt");
            e = '0; e.halted = 1;
            for (int i = 0; i < 3; i++) cyc(rbit(), rbit(), e, "HALT_op");
            st = 2;
            return;
        end
        if (!(alu || md)) begin
            e = '0; e.illegal = 1;
            cyc(run_after, rbit(), e, "T3_illegal");
            st = run_after ? 1 : 0;
            return;
        end
        e = '0; e.rout = 16'h1 << instr[22:19]; e.y_in = 1;
        cyc(rbit(), rbit(), e, "T3");

        e = '0; e.rout = 16'h1 << instr[18:15]; e.z_in = 1; e.opc = op;
        if (abort_t4) begin
            run = 1'b1;
            mem_ready = 1'b1;
            #2;
            check(e, "T4_before_clear");
            clear = 1'b0;
            #1;
            check('0, "clear_mid_T4");
            @(posedge clock);
            #1;
            check('0, "clear_held");
            clear = 1'b1;
            run = 1'b0;
            st = 0;
            return;
        end
        cyc(rbit(), rbit(), e, "T4");

        if (md) begin
            e = '0; e.zlo_out = 1; e.lo_in = 1;
            cyc(rbit(), rbit(), e, "T5_lo");
            e = '0; e.zhi_out = 1; e.hi_in = 1; e.done = 1;
            cyc(run_after, rbit(), e, "T6_hi");
        end else begin
            e = '0; e.zlo_out = 1; e.rin = 16'h1 << instr[26:23]; e.done = 1;
            cyc(run_after, rbit(), e, "T5");
        end
        st = run_after ? 1 : 0;
    endtask

    // Bring the DUT from IDLE or HALT to T0.
    task automatic start(input int st);
        if (st == 2) do_reset();
        if (st != 1) cyc(1'b1, rbit(), '0, "IDLE_go");
    endtask

    initial begin
        int st;
        logic [31:0] rnd_ir;
        logic [4:0]  rop;
        int          w;

        clear = 1'b0; run = 1'b1; mem_ready = 1'b1; ir = 32'h1A1B8000;
        #3;
        check('0, "reset_init");
        @(posedge clock);
        #1;
        check('0, "reset_hold");
        clear = 1'b1;
        run = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, rbit(), '0, "IDLE_stay");

        cyc(1'b1, rbit(), '0, "IDLE_go");
        exec(32'h1A1B8000, 0, 1'b1, 1'b0, st);          // add R4,R3,R7, back-to-back
        exec(32'h1A1B8000, 3, 1'b0, 1'b0, st);          // three wait cycles
        start(st);
        exec(32'h1A1B8000, 0, 1'b1, 1'b1, st);          // clear during T4
        for (int i = 0; i < 2; i++) cyc(1'b0, rbit(), '0, "IDLE_after_clear");
        start(st);
        exec(32'hF8000000, 0, 1'b1, 1'b0, st);          // illegal 11111
        exec(32'h7A1B8000, 0, 1'b1, 1'b0, st);          // mul
        exec(32'h821B8000, 1, 1'b0, 1'b0, st);          // div
        start(st);
        exec(32'h4C888000, MEM_TO - 1, 1'b1, 1'b0, st); // ready on the last allowed cycle
        exec(32'h1A1B8000, MEM_TO, 1'b1, 1'b0, st);     // timeout
        start(st);
        exec(32'hD8000000, 0, 1'b1, 1'b0, st);          // halt opcode
        start(st);
        exec(32'h18000000, 0, 1'b1, 1'b0, st);          // Ra=Rb=Rc=R0
        exec(32'h57FF8000, 2, 1'b0, 1'b0, st);          // Ra=Rb=Rc=R15

        for (int k = 0; k < 40; k++) begin
            start(st);
            case ($urandom_range(9, 0))
                0:       rop = 5'd27;
                1, 2:    rop = 5'($urandom_range(31, 0));
                3:       rop = rbit() ? 5'd15 : 5'd16;
                default: rop = 5'($urandom_range(10, 3));
            endcase
            rnd_ir = $urandom();
            rnd_ir[31:27] = rop;
            w = ($urandom_range(11, 0) == 0) ? MEM_TO : int'($urandom_range(4, 0));
            exec(rnd_ir, w, rbit(), 1'b0, st);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
